// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
//  Module   : pipeline_ctrl_pkg
//  Purpose  : Shared state codes, default widths and a width helper for the
//             5-stage pipeline controller.
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

  localparam int NB_REG_DEFAULT       = 5;
  localparam int DRAIN_CYCLES_DEFAULT = 4;
  localparam int NB_CNT_DEFAULT       = 32;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Bits needed to hold values 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
// ============================================================================
//  Module   : pipeline_ctrl_if
//  Purpose  : Bundle of debug, decode/EX/MEM hazard inputs and the stage
//             enable/flush, halt and counter outputs of the controller.
//             master = datapath/debug side, slave = controller.
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

interface pipeline_ctrl_if #(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 32
);

  logic              i_dbg_run;
  logic              i_dbg_step;
  logic              i_dbg_stop;
  logic              i_ID_halt;
  logic [NB_REG-1:0] i_ID_rs;
  logic [NB_REG-1:0] i_ID_rt;
  logic              i_EX_mem_read;
  logic [NB_REG-1:0] i_EX_rt;
  logic              i_MEM_branch_taken;

  logic              o_pc_en;
  logic              o_IF_ID_en;
  logic              o_ID_EX_en;
  logic              o_EX_MEM_en;
  logic              o_MEM_WB_en;
  logic              o_IF_ID_flush;
  logic              o_ID_EX_flush;
  logic              o_EX_MEM_flush;
  logic              o_halted;
  logic [NB_CNT-1:0] o_cycle_count;
  logic [NB_CNT-1:0] o_stall_count;
  logic [NB_CNT-1:0] o_flush_count;

  modport master (
    output i_dbg_run, i_dbg_step, i_dbg_stop, i_ID_halt, i_ID_rs, i_ID_rt,
           i_EX_mem_read, i_EX_rt, i_MEM_branch_taken,
    input  o_pc_en, o_IF_ID_en, o_ID_EX_en, o_EX_MEM_en, o_MEM_WB_en,
           o_IF_ID_flush, o_ID_EX_flush, o_EX_MEM_flush, o_halted,
           o_cycle_count, o_stall_count, o_flush_count
  );

  modport slave (
    input  i_dbg_run, i_dbg_step, i_dbg_stop, i_ID_halt, i_ID_rs, i_ID_rt,
           i_EX_mem_read, i_EX_rt, i_MEM_branch_taken,
    output o_pc_en, o_IF_ID_en, o_ID_EX_en, o_EX_MEM_en, o_MEM_WB_en,
           o_IF_ID_flush, o_ID_EX_flush, o_EX_MEM_flush, o_halted,
           o_cycle_count, o_stall_count, o_flush_count
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ============================================================================
//  Module   : pipeline_ctrl_hazard_detect
//  Purpose  : Load-use hazard compare: a load in EX whose destination (not
//             $zero) is a source of the instruction currently in ID.
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int NB_REG = NB_REG_DEFAULT
) (
  input  logic              mem_read,
  input  logic [NB_REG-1:0] ex_rt,
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  output logic              stall
);

  // $zero never carries a dependency, so it is excluded from the compare
  assign stall = mem_read && (ex_rt != '0) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
//  Module   : pipeline_ctrl
//  Purpose  : Sequencer for the 5-stage MIPS pipeline. Drives stage register
//             enables/flushes, handles debug run/step/stop, load-use stalls,
//             branch flushes and the HALT drain into HALTED.
//  Options  : PIPE_CTRL_PERF_CNT_EN - enables the stall/flush perf counters;
//             when undefined both counter outputs are tied to zero.
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NB_REG       = NB_REG_DEFAULT,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int NB_CNT       = NB_CNT_DEFAULT
) (
  input  logic           i_clock,
  input  logic           i_reset_n,
  pipeline_ctrl_if.slave bus
);

  localparam int                 NB_DCNT    = cnt_width(DRAIN_CYCLES);
  localparam logic [NB_DCNT-1:0] DRAIN_INIT = NB_DCNT'(DRAIN_CYCLES - 1);

  state_t             state;
  logic               step_mode;
  logic [NB_DCNT-1:0] drain_cnt;
  logic               halted;
  logic [NB_CNT-1:0]  cycle_cnt;

  logic adv;
  logic load_use;
  logic in_drain;
  logic stop_req;
  logic run_req;
  logic step_req;
  logic branch;
  logic halt_hit;
  logic halt_apply;
  logic stall_apply;
  logic drain_step_mode;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush;

  pipeline_ctrl_hazard_detect #(
    .NB_REG (NB_REG)
  ) u_hazard (
    .mem_read (bus.i_EX_mem_read),
    .ex_rt    (bus.i_EX_rt),
    .id_rs    (bus.i_ID_rs),
    .id_rt    (bus.i_ID_rt),
    .stall    (load_use)
  );

  // Debug pulses resolved by precedence stop > run > step
  assign stop_req = bus.i_dbg_stop;
  assign run_req  = bus.i_dbg_run & ~bus.i_dbg_stop;
  assign step_req = bus.i_dbg_step & ~bus.i_dbg_stop & ~bus.i_dbg_run;

  assign in_drain    = (state == ST_DRAIN);
  assign branch      = bus.i_MEM_branch_taken;
  // HALT seen in ID only matters outside DRAIN; during DRAIN ID holds bubbles
  assign halt_hit    = bus.i_ID_halt & ~in_drain;
  assign halt_apply  = adv & ~branch & halt_hit;
  assign stall_apply = adv & ~branch & ~in_drain & ~bus.i_ID_halt & load_use;

  // step_mode as it will be after this cycle's debug pulses while draining
  assign drain_step_mode = stop_req ? 1'b1 : (run_req ? 1'b0 : step_mode);

  // Advance qualifier; forced low while reset is held so nothing moves
  always_comb begin
    adv = 1'b0;
    if (i_reset_n) begin
      case (state)
        ST_IDLE:   adv = step_req;
        ST_RUN:    adv = 1'b1;
        ST_DRAIN:  adv = ~step_mode | step_req;
        ST_HALTED: adv = 1'b0;
        default:   adv = 1'b0;
      endcase
    end
  end

  // Stage enables/flushes: all on when advancing, then branch > halt/drain > load-use
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (adv) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (branch) begin
        // pc_en stays high so the branch target is loaded
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (in_drain || halt_hit) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end else if (stall_apply) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Sequencing FSM with step_mode, drain counter, halt flag and cycle counter
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      step_mode <= 1'b1;
      drain_cnt <= '0;
      halted    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if (adv && (cycle_cnt != '1)) begin
        cycle_cnt <= cycle_cnt + NB_CNT'(1);
      end
      case (state)
        ST_IDLE: begin
          if (halt_apply) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_INIT;
          end else if (run_req) begin
            state     <= ST_RUN;
            step_mode <= 1'b0;
          end
        end
        ST_RUN: begin
          if (halt_apply) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_INIT;
            step_mode <= stop_req;
          end else if (stop_req) begin
            state     <= ST_IDLE;
            step_mode <= 1'b1;
          end
        end
        ST_DRAIN: begin
          step_mode <= drain_step_mode;
          if (adv) begin
            if (branch) begin
              // HALT was on the wrong path: resume in the current debug mode
              state     <= drain_step_mode ? ST_IDLE : ST_RUN;
              drain_cnt <= '0;
            end else if (drain_cnt == '0) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - NB_DCNT'(1);
            end
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_pc_en        = pc_en;
  assign bus.o_IF_ID_en     = if_id_en;
  assign bus.o_ID_EX_en     = id_ex_en;
  assign bus.o_EX_MEM_en    = ex_mem_en;
  assign bus.o_MEM_WB_en    = mem_wb_en;
  assign bus.o_IF_ID_flush  = if_id_flush;
  assign bus.o_ID_EX_flush  = id_ex_flush;
  assign bus.o_EX_MEM_flush = ex_mem_flush;
  assign bus.o_halted       = halted;
  assign bus.o_cycle_count  = cycle_cnt;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [NB_CNT-1:0] stall_cnt;
  logic [NB_CNT-1:0] flush_cnt;

  // Saturating counts of applied load-use stalls and branch flushes
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_apply && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + NB_CNT'(1);
      end
      if (adv && branch && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + NB_CNT'(1);
      end
    end
  end

  assign bus.o_stall_count = stall_cnt;
  assign bus.o_flush_count = flush_cnt;
`else
  assign bus.o_stall_count = '0;
  assign bus.o_flush_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
//  Module   : tb_pipeline_ctrl
//  Purpose  : Self-checking bench for pipeline_ctrl: table of RUN-mode hazard
//             vectors plus directed sequences for step/stop, HALT drain,
//             branch during drain and reset during drain.
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

  // Output vector bit order: pc, IF_ID, ID_EX, EX_MEM, MEM_WB enables, then
  // IF_ID, ID_EX, EX_MEM flushes
  localparam logic [7:0] E_NONE  = 8'h00;
  localparam logic [7:0] E_ALL   = 8'hF8;
  localparam logic [7:0] E_STALL = 8'h3A;
  localparam logic [7:0] E_BR    = 8'hFF;
  localparam logic [7:0] E_DRAIN = 8'h7C;

  typedef struct packed {
    logic       branch;
    logic       halt;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   exp_cycle = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  vec_t vecs [10];

  pipeline_ctrl_if #(.NB_REG(5), .NB_CNT(32)) bus ();

  pipeline_ctrl #(
    .NB_REG       (5),
    .DRAIN_CYCLES (4),
    .NB_CNT       (32)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] outs;
  assign outs = {bus.o_pc_en, bus.o_IF_ID_en, bus.o_ID_EX_en, bus.o_EX_MEM_en,
                 bus.o_MEM_WB_en, bus.o_IF_ID_flush, bus.o_ID_EX_flush,
                 bus.o_EX_MEM_flush};

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    bus.i_dbg_run          = 1'b0;
    bus.i_dbg_step         = 1'b0;
    bus.i_dbg_stop         = 1'b0;
    bus.i_ID_halt          = 1'b0;
    bus.i_ID_rs            = '0;
    bus.i_ID_rt            = '0;
    bus.i_EX_mem_read      = 1'b0;
    bus.i_EX_rt            = '0;
    bus.i_MEM_branch_taken = 1'b0;
  endtask

  task automatic set_in(input logic br, input logic hlt, input logic mr,
                        input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt);
    bus.i_MEM_branch_taken = br;
    bus.i_ID_halt          = hlt;
    bus.i_EX_mem_read      = mr;
    bus.i_EX_rt            = ert;
    bus.i_ID_rs            = rs;
    bus.i_ID_rt            = rt;
  endtask

  // Called just after a negedge with inputs set: check outputs, clock once,
  // update the counter model, clear inputs, return on the next negedge.
  task automatic cyc(input string nm, input logic [7:0] exp);
    #2;
    check8(nm, outs, exp);
    @(posedge clk);
    if (exp[3]) exp_cycle++;
    if (exp == E_STALL) exp_stall++;
    if (exp[0]) exp_flush++;
    #1;
    clear_in();
    @(negedge clk);
  endtask

  task automatic check_perf(input string nm);
`ifdef PIPE_CTRL_PERF_CNT_EN
    check32({nm, "_stall_cnt"}, bus.o_stall_count, exp_stall);
    check32({nm, "_flush_cnt"}, bus.o_flush_count, exp_flush);
`else
    check32({nm, "_stall_cnt"}, bus.o_stall_count, 0);
    check32({nm, "_flush_cnt"}, bus.o_flush_count, 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd0, 5'd0,  E_ALL};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 5'd5,  5'd5, 5'd0,  E_STALL};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 5'd5,  5'd5, 5'd0,  E_ALL};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 5'd5,  5'd1, 5'd5,  E_STALL};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd0, 5'd0,  E_ALL};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 5'd7,  5'd3, 5'd4,  E_ALL};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 5'd5,  5'd5, 5'd0,  E_BR};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 5'd0,  5'd0, 5'd0,  E_BR};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd0, 5'd0,  E_ALL};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 5'd31, 5'd2, 5'd31, E_STALL};

    clear_in();
    // Reset held: a step pulse must not produce any enable
    #3;
    bus.i_dbg_step = 1'b1;
    #1;
    check8("reset_outputs", outs, E_NONE);
    check32("reset_halted", 32'(bus.o_halted), 0);
    check32("reset_cycle", bus.o_cycle_count, 0);
    check_perf("reset");
    clear_in();
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE stepping
    cyc("idle_no_adv", E_NONE);
    for (int i = 0; i < 3; i++) begin
      bus.i_dbg_step = 1'b1;
      cyc($sformatf("idle_step%0d", i), E_ALL);
    end
    check32("step_cycle_count", bus.o_cycle_count, 3);
    bus.i_dbg_stop = 1'b1;
    bus.i_dbg_step = 1'b1;
    cyc("stop_plus_step", E_NONE);
    check32("stop_step_cycle_count", bus.o_cycle_count, 3);

    // Enter RUN and apply the hazard table
    bus.i_dbg_run = 1'b1;
    cyc("run_enter", E_NONE);
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].branch, vecs[i].halt, vecs[i].mem_read,
             vecs[i].ex_rt, vecs[i].id_rs, vecs[i].id_rt);
      cyc($sformatf("vec%0d", i), vecs[i].exp);
    end
    check32("run_cycle_count", bus.o_cycle_count, exp_cycle);
    check_perf("run");

    // HALT from RUN: halt cycle then exactly 4 drain advances
    set_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    cyc("halt_in_id", E_DRAIN);
    for (int i = 0; i < 4; i++) begin
      check32($sformatf("not_halted%0d", i), 32'(bus.o_halted), 0);
      cyc($sformatf("drain%0d", i), E_DRAIN);
    end
    check32("halted_flag", 32'(bus.o_halted), 1);
    cyc("halted_idle", E_NONE);
    bus.i_dbg_step = 1'b1;
    cyc("halted_step", E_NONE);
    bus.i_dbg_run = 1'b1;
    cyc("halted_run", E_NONE);
    check32("halted_cycle_count", bus.o_cycle_count, exp_cycle);
    check32("halted_flag_hold", 32'(bus.o_halted), 1);

    // Reset mid-DRAIN (drain counter at 2)
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cycle = 0;
    exp_stall = 0;
    exp_flush = 0;
    bus.i_dbg_run = 1'b1;
    cyc("rerun_enter", E_NONE);
    set_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    cyc("rerun_halt", E_DRAIN);
    cyc("rerun_drain0", E_DRAIN);
    #3;
    rst_n = 1'b0;
    #1;
    check8("midreset_outputs", outs, E_NONE);
    check32("midreset_cycle", bus.o_cycle_count, 0);
    check32("midreset_halted", 32'(bus.o_halted), 0);
    check_perf("midreset");
    exp_cycle = 0;
    exp_stall = 0;
    exp_flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_reset_idle", E_NONE);
    bus.i_dbg_step = 1'b1;
    cyc("post_reset_step", E_ALL);

    // Branch resolves taken while draining: wrong-path HALT, back to RUN
    bus.i_dbg_run = 1'b1;
    cyc("br_run_enter", E_NONE);
    set_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    cyc("br_halt", E_DRAIN);
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cyc("br_in_drain", E_BR);
    cyc("br_back_to_run", E_ALL);
    bus.i_dbg_stop = 1'b1;
    cyc("stop_in_run", E_ALL);
    cyc("stopped_idle", E_NONE);

    // Step-gated drain entered from IDLE, then released by run
    bus.i_dbg_step = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    cyc("step_halt", E_DRAIN);
    cyc("drain_wait", E_NONE);
    bus.i_dbg_step = 1'b1;
    cyc("drain_step", E_DRAIN);
    bus.i_dbg_run = 1'b1;
    cyc("drain_run_pulse", E_NONE);
    cyc("drain_free0", E_DRAIN);
    cyc("drain_free1", E_DRAIN);
    cyc("drain_free2", E_DRAIN);
    cyc("drain_done", E_NONE);
    check32("step_drain_halted", 32'(bus.o_halted), 1);
    check32("final_cycle_count", bus.o_cycle_count, exp_cycle);
    check_perf("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
